multi_mode_timekeeper: RTL and testbench
========================================

MULTI_MODE_TIMEKEEPER -- requirements
Module: multi_mode_timekeeper

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, sub-second resolution; legal 2..100; CLK_HZ divisible by TICK_HZ.
REQ-003 SHALL have parameter HOUR_MOD, default 24, hour wrap modulus; legal 2..32.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  system clock.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port i_mode  input  2  00 stopwatch, 01 clock, 10 countdown, 11 treated as 01.
REQ-008 SHALL have ports i_btn_run, i_btn_clear, i_btn_sec, i_btn_min, i_btn_hour  input  1 each  debounced single-cycle pulses.
REQ-009 SHALL have port o_msec  output  7  sub-second field, 0..TICK_HZ-1.
REQ-010 SHALL have ports o_sec, o_min  output  6 each  0..59.
REQ-011 SHALL have port o_hour  output  5  0..HOUR_MOD-1.
REQ-012 SHALL have port o_running  output  1  run flag of the selected mode (1 in clock mode).
REQ-013 SHALL have port o_expired  output  1  countdown reached zero.

Function
REQ-014 SHALL generate a free-running one-cycle tick every CLK_HZ/TICK_HZ cycles, shared by all engines.
REQ-015 SHALL keep three independent time registers (stopwatch, clock, countdown); all advance on tick regardless of i_mode.
REQ-016 SHALL update a register on the clk edge where tick is high; outputs show new value one cycle later (combinational mux of registers by i_mode).
REQ-017 Up-count: msec wraps TICK_HZ-1->0 carrying to sec, sec 59->0 carrying to min, min 59->0 carrying to hour, hour HOUR_MOD-1->0.
REQ-018 Buttons SHALL act only on the engine selected by i_mode; others ignore them.
REQ-019 Stopwatch: run toggles run flag; clear zeroes all fields and clears run flag; counts up only while running.
REQ-020 Clock: always running; sec/min/hour pulses increment that field modulo its range without carry; sec pulse also zeroes msec.
REQ-021 Clock: tick and adjust pulse in the same cycle SHALL both apply, tick first, then increment on the result.
REQ-022 Countdown: while stopped, sec/min/hour pulses increment preset field (no carry) and the displayed value equals the preset; ignored while running.
REQ-023 Countdown: run while stopped and value nonzero starts; run while running pauses; run at value zero ignored.
REQ-024 Countdown: decrements per tick with borrow (msec 0->TICK_HZ-1, sec 0->59, min 0->59); on reaching all-zero SHALL clear run flag and set o_expired in the same edge.
REQ-025 Countdown: o_expired SHALL hold until run or clear pulse in countdown mode; clear zeroes value and stops.
REQ-026 Stopwatch clear and run in the same cycle: clear wins, run flag 0.
REQ-027 Changing i_mode SHALL not alter any register or run flag.

Reset
REQ-028 On rst all time registers, run flags, tick divider and o_expired SHALL be 0; outputs read 0, o_running 0 (1 if i_mode selects clock).
REQ-029 rst mid-count SHALL take priority over tick and buttons in the same cycle.

Configuration
REQ-030 Macro COUNTDOWN_EN: defined -> countdown engine present per REQ-022..025; undefined -> no countdown logic, i_mode 10 treated as 00, o_expired tied 0.

Verification (CLK_HZ=1000, TICK_HZ=100, HOUR_MOD=24: tick every 10 cycles)
REQ-031 Stopwatch: rst, run, 1000 cycles -> o_msec 0, o_sec 1; clear -> all 0, o_running 0.
REQ-032 Clock: set 23:59:59.99 via buttons/ticks, one tick -> 00:00:00.00; sec pulse coincident with tick at sec 59 -> sec 0 after carry, plus 1 = 1.
REQ-033 Countdown (COUNTDOWN_EN): preset sec=1, run, 100 ticks -> 0:00:00.00, o_expired 1, o_running 0; run pulse -> o_expired 0, stays stopped.
REQ-034 Mode switch: stopwatch running, switch to clock for 500 cycles, back -> stopwatch advanced 50 ticks.
REQ-035 rst asserted mid-count with run pulse same cycle -> all outputs 0, o_running 0; COUNTDOWN_EN undefined build: i_mode 10 behaves as stopwatch, o_expired 0.

Source files
------------

// File: rtl/multi_mode_timekeeper.sv
// multi_mode_timekeeper
// Stopwatch, time-of-day clock and (optionally) countdown timer driven by one
// shared sub-second tick. All engines run continuously; i_mode only picks
// which engine receives the buttons and which one is shown on the outputs.
// Optional feature macro: COUNTDOWN_EN (defined -> countdown engine present;
// undefined -> mode 2'b10 behaves as stopwatch and o_expired is tied low).

`timescale 1ns/1ps

module multi_mode_timekeeper #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 100,
    parameter int HOUR_MOD = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_mode,
    input  logic       i_btn_run,
    input  logic       i_btn_clear,
    input  logic       i_btn_sec,
    input  logic       i_btn_min,
    input  logic       i_btn_hour,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_running,
    output logic       o_expired
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [6:0]       MS_LAST  = 7'(TICK_HZ - 1);
    localparam logic [5:0]       SM_LAST  = 6'd59;
    localparam logic [4:0]       HR_LAST  = 5'(HOUR_MOD - 1);

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] msec;
    } time_t;

    typedef enum logic [1:0] {
        ENG_SW  = 2'd0,
        ENG_CLK = 2'd1,
        ENG_CD  = 2'd2
    } eng_e;

    // Single-field increments used by the adjust buttons (no carry out).
    function automatic logic [5:0] f_wrap60(input logic [5:0] v);
        return (v == SM_LAST) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] f_wrap_hr(input logic [4:0] v);
        return (v == HR_LAST) ? 5'd0 : v + 5'd1;
    endfunction

    // Full up-count with carry through every field.
    function automatic time_t f_inc(input time_t t);
        time_t r;
        r = t;
        if (t.msec != MS_LAST) begin
            r.msec = t.msec + 7'd1;
        end else begin
            r.msec = 7'd0;
            r.sec  = f_wrap60(t.sec);
            if (t.sec == SM_LAST) begin
                r.min = f_wrap60(t.min);
                if (t.min == SM_LAST) begin
                    r.hour = f_wrap_hr(t.hour);
                end
            end
        end
        return r;
    endfunction

`ifdef COUNTDOWN_EN
    // Full down-count with borrow; never called on an all-zero value because
    // the countdown stops itself on reaching zero.
    function automatic time_t f_dec(input time_t t);
        time_t r;
        r = t;
        if (t.msec != 7'd0) begin
            r.msec = t.msec - 7'd1;
        end else begin
            r.msec = MS_LAST;
            if (t.sec != 6'd0) begin
                r.sec = t.sec - 6'd1;
            end else begin
                r.sec = SM_LAST;
                if (t.min != 6'd0) begin
                    r.min = t.min - 6'd1;
                end else begin
                    r.min  = SM_LAST;
                    r.hour = t.hour - 5'd1;
                end
            end
        end
        return r;
    endfunction
`endif

    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    eng_e             w_sel;

    time_t r_sw;
    logic  r_sw_run;
    time_t r_clk;
    time_t w_clk_next;
    time_t w_disp;

    // Tick divider: free-running, one-cycle strobe on the last count.
    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Decode which engine owns the buttons and the display.
    always_comb begin
        w_sel = ENG_CLK;
        case (i_mode)
            2'b00: w_sel = ENG_SW;
`ifdef COUNTDOWN_EN
            2'b10: w_sel = ENG_CD;
`else
            2'b10: w_sel = ENG_SW;
`endif
            default: w_sel = ENG_CLK;
        endcase
    end

    // Stopwatch: counts while running; clear beats run and beats the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw     <= '0;
            r_sw_run <= 1'b0;
        end else if (w_sel == ENG_SW && i_btn_clear) begin
            r_sw     <= '0;
            r_sw_run <= 1'b0;
        end else begin
            if (w_tick && r_sw_run) begin
                r_sw <= f_inc(r_sw);
            end
            if (w_sel == ENG_SW && i_btn_run) begin
                r_sw_run <= ~r_sw_run;
            end
        end
    end

    // Clock next value: tick applied first, then field adjusts on the result.
    // NOTE: blocking assignments here build the value step by step within one
    // cycle; the register itself is only ever written with <= below.
    always_comb begin
        w_clk_next = r_clk;
        if (w_tick) begin
            w_clk_next = f_inc(r_clk);
        end
        if (w_sel == ENG_CLK) begin
            if (i_btn_hour) begin
                w_clk_next.hour = f_wrap_hr(w_clk_next.hour);
            end
            if (i_btn_min) begin
                w_clk_next.min = f_wrap60(w_clk_next.min);
            end
            if (i_btn_sec) begin
                w_clk_next.sec  = f_wrap60(w_clk_next.sec);
                w_clk_next.msec = 7'd0;
            end
        end
    end

    // Clock register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk <= '0;
        end else begin
            r_clk <= w_clk_next;
        end
    end

`ifdef COUNTDOWN_EN
    time_t r_cd;
    logic  r_cd_run;
    logic  r_cd_exp;
    time_t w_cd_next;
    logic  w_cd_run_next;
    logic  w_cd_exp_next;

    // Countdown next state: tick/expiry first, then buttons on the result.
    always_comb begin
        w_cd_next     = r_cd;
        w_cd_run_next = r_cd_run;
        w_cd_exp_next = r_cd_exp;
        if (w_tick && r_cd_run) begin
            w_cd_next = f_dec(r_cd);
            if (w_cd_next == '0) begin
                w_cd_run_next = 1'b0;
                w_cd_exp_next = 1'b1;
            end
        end
        if (w_sel == ENG_CD) begin
            if (i_btn_clear) begin
                w_cd_next     = '0;
                w_cd_run_next = 1'b0;
                w_cd_exp_next = 1'b0;
            end else if (i_btn_run) begin
                w_cd_exp_next = 1'b0;
                if (w_cd_run_next) begin
                    w_cd_run_next = 1'b0;
                end else if (w_cd_next != '0) begin
                    w_cd_run_next = 1'b1;
                end
            end else if (!w_cd_run_next) begin
                // Stopped: the value itself is the preset being edited.
                if (i_btn_hour) begin
                    w_cd_next.hour = f_wrap_hr(w_cd_next.hour);
                end
                if (i_btn_min) begin
                    w_cd_next.min = f_wrap60(w_cd_next.min);
                end
                if (i_btn_sec) begin
                    w_cd_next.sec = f_wrap60(w_cd_next.sec);
                end
            end
        end
    end

    // Countdown registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cd     <= '0;
            r_cd_run <= 1'b0;
            r_cd_exp <= 1'b0;
        end else begin
            r_cd     <= w_cd_next;
            r_cd_run <= w_cd_run_next;
            r_cd_exp <= w_cd_exp_next;
        end
    end

    assign o_expired = r_cd_exp;
`else
    assign o_expired = 1'b0;
`endif

    // Display mux: selected engine's time and run flag.
    always_comb begin
        w_disp    = r_clk;
        o_running = 1'b1;
        case (w_sel)
            ENG_SW: begin
                w_disp    = r_sw;
                o_running = r_sw_run;
            end
`ifdef COUNTDOWN_EN
            ENG_CD: begin
                w_disp    = r_cd;
                o_running = r_cd_run;
            end
`endif
            default: begin
                w_disp    = r_clk;
                o_running = 1'b1;
            end
        endcase
    end

    assign o_hour = w_disp.hour;
    assign o_min  = w_disp.min;
    assign o_sec  = w_disp.sec;
    assign o_msec = w_disp.msec;

endmodule

// File: tb/tb_multi_mode_timekeeper.sv
// Self-checking bench for multi_mode_timekeeper (CLK_HZ=1000, TICK_HZ=100).
// The reference model keeps each engine as one integer count of ticks and
// derives fields by division; a compare process checks every cycle, and
// directed literal checks pin the model at hand-computed points.

`timescale 1ns/1ps

module tb_multi_mode_timekeeper;

    localparam int CLK_HZ   = 1000;
    localparam int TICK_HZ  = 100;
    localparam int HOUR_MOD = 24;
    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int FULL     = HOUR_MOD * 3600 * TICK_HZ;

    localparam bit [4:0] B_RUN   = 5'b00001;
    localparam bit [4:0] B_CLEAR = 5'b00010;
    localparam bit [4:0] B_SEC   = 5'b00100;
    localparam bit [4:0] B_MIN   = 5'b01000;
    localparam bit [4:0] B_HOUR  = 5'b10000;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [1:0] i_mode = 2'b00;
    logic       b_run = 1'b0, b_clear = 1'b0, b_sec = 1'b0, b_min = 1'b0, b_hour = 1'b0;
    logic [6:0] o_msec;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hour;
    logic       o_running, o_expired;
    logic [25:0] dut_vec;

    multi_mode_timekeeper #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .HOUR_MOD(HOUR_MOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_mode     (i_mode),
        .i_btn_run  (b_run),
        .i_btn_clear(b_clear),
        .i_btn_sec  (b_sec),
        .i_btn_min  (b_min),
        .i_btn_hour (b_hour),
        .o_msec     (o_msec),
        .o_sec      (o_sec),
        .o_min      (o_min),
        .o_hour     (o_hour),
        .o_running  (o_running),
        .o_expired  (o_expired)
    );

    always #5 clk = ~clk;

    assign dut_vec = {o_hour, o_min, o_sec, o_msec, o_running, o_expired};

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // ---------------- reference model ----------------
    int m_cyc    = 0;
    int m_sw     = 0;
    int m_clk    = 0;
    int m_cd     = 0;
    bit m_sw_run = 1'b0;
    bit m_cd_run = 1'b0;
    bit m_cd_exp = 1'b0;

    function automatic int fl_ms(input int t); return t % TICK_HZ;                endfunction
    function automatic int fl_s (input int t); return (t / TICK_HZ) % 60;         endfunction
    function automatic int fl_m (input int t); return (t / (TICK_HZ * 60)) % 60;  endfunction
    function automatic int fl_h (input int t); return t / (TICK_HZ * 3600);       endfunction

    function automatic int compose(input int h, input int m, input int s, input int ms);
        return ((h * 60 + m) * 60 + s) * TICK_HZ + ms;
    endfunction

    function automatic logic [25:0] pk(input int h, input int m, input int s, input int ms,
                                       input bit run, input bit ex);
        return {5'(h), 6'(m), 6'(s), 7'(ms), run, ex};
    endfunction

    function automatic int eff_mode(input logic [1:0] md);
        case (md)
            2'b00: return 0;
`ifdef COUNTDOWN_EN
            2'b10: return 2;
`else
            2'b10: return 0;
`endif
            default: return 1;
        endcase
    endfunction

    function automatic bit next_is_tick();
        return !rst && ((m_cyc % DIV) == DIV - 1);
    endfunction

    function automatic logic [25:0] model_out(input logic [1:0] md);
        int em;
        em = eff_mode(md);
        if (em == 0) return pk(fl_h(m_sw), fl_m(m_sw), fl_s(m_sw), fl_ms(m_sw), m_sw_run, m_cd_exp);
        if (em == 2) return pk(fl_h(m_cd), fl_m(m_cd), fl_s(m_cd), fl_ms(m_cd), m_cd_run, m_cd_exp);
        return pk(fl_h(m_clk), fl_m(m_clk), fl_s(m_clk), fl_ms(m_clk), 1'b1, m_cd_exp);
    endfunction

    always @(posedge clk) begin : model
        bit tick;
        int em, h, m, s, ms;
        if (rst) begin
            m_cyc = 0; m_sw = 0; m_clk = 0; m_cd = 0;
            m_sw_run = 1'b0; m_cd_run = 1'b0; m_cd_exp = 1'b0;
        end else begin
            tick = ((m_cyc % DIV) == DIV - 1);
            m_cyc++;
            em = eff_mode(i_mode);
            // stopwatch
            if (tick && m_sw_run) m_sw = (m_sw + 1) % FULL;
            if (em == 0) begin
                if (b_clear) begin
                    m_sw = 0; m_sw_run = 1'b0;
                end else if (b_run) begin
                    m_sw_run = !m_sw_run;
                end
            end
            // clock
            if (tick) m_clk = (m_clk + 1) % FULL;
            if (em == 1) begin
                h = fl_h(m_clk); m = fl_m(m_clk); s = fl_s(m_clk); ms = fl_ms(m_clk);
                if (b_hour) h = (h + 1) % HOUR_MOD;
                if (b_min)  m = (m + 1) % 60;
                if (b_sec) begin s = (s + 1) % 60; ms = 0; end
                m_clk = compose(h, m, s, ms);
            end
            // countdown
            if (tick && m_cd_run) begin
                m_cd--;
                if (m_cd == 0) begin m_cd_run = 1'b0; m_cd_exp = 1'b1; end
            end
            if (em == 2) begin
                if (b_clear) begin
                    m_cd = 0; m_cd_run = 1'b0; m_cd_exp = 1'b0;
                end else if (b_run) begin
                    m_cd_exp = 1'b0;
                    if (m_cd_run) m_cd_run = 1'b0;
                    else if (m_cd != 0) m_cd_run = 1'b1;
                end else if (!m_cd_run) begin
                    h = fl_h(m_cd); m = fl_m(m_cd); s = fl_s(m_cd); ms = fl_ms(m_cd);
                    if (b_hour) h = (h + 1) % HOUR_MOD;
                    if (b_min)  m = (m + 1) % 60;
                    if (b_sec)  s = (s + 1) % 60;
                    m_cd = compose(h, m, s, ms);
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [25:0] got, input logic [25:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d:%0d:%0d.%0d run=%0b exp=%0b, want %0d:%0d:%0d.%0d run=%0b exp=%0b",
                     name, $time, got[25:21], got[20:15], got[14:9], got[8:2], got[1], got[0],
                     exp[25:21], exp[20:15], exp[14:9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Every cycle, once the first reset edge has been seen.
    always @(posedge clk) begin
        #1;
        if (chk_en) check("cycle", dut_vec, model_out(i_mode));
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic press(input bit [4:0] b);
        {b_hour, b_min, b_sec, b_clear, b_run} = b;
        @(negedge clk);
        {b_hour, b_min, b_sec, b_clear, b_run} = 5'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_clk_value(input int target, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (m_clk == target) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) timeout(name);
    endtask

    task automatic wait_tick_next(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < DIV + 2; i++) begin
            if (next_is_tick()) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) timeout(name);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_state", dut_vec, pk(0, 0, 0, 0, 0, 0));
        i_mode = 2'b01; #1;
        check("reset_clock_running", dut_vec, pk(0, 0, 0, 0, 1, 0));
        i_mode = 2'b00;
        rst = 1'b0;

        // Stopwatch: run, 1000 cycles = 100 ticks = 1 s; then clear.
        press(B_RUN);
        repeat (1000) @(negedge clk);
        check("sw_1s", dut_vec, pk(0, 0, 1, 0, 1, 0));
        press(B_CLEAR);
        check("sw_clear", dut_vec, pk(0, 0, 0, 0, 0, 0));

        // Pause: 5 ticks then stop, value must freeze.
        press(B_RUN);
        repeat (47) @(negedge clk);
        press(B_RUN);
        repeat (30) @(negedge clk);
        check("sw_paused", dut_vec, pk(0, 0, 0, 5, 0, 0));

        // Clear and run together: clear wins.
        press(B_RUN);
        repeat (20) @(negedge clk);
        press(B_RUN | B_CLEAR);
        check("sw_clear_and_run", dut_vec, pk(0, 0, 0, 0, 0, 0));

        // Mode switch: stopwatch keeps counting while clock is displayed.
        do_reset();
        press(B_RUN);
        repeat (99) @(negedge clk);
        check("sw_before_switch", dut_vec, pk(0, 0, 0, 10, 1, 0));
        i_mode = 2'b01;
        repeat (500) @(negedge clk);
        #1;
        check("clk_during_switch", dut_vec, pk(0, 0, 0, 60, 1, 0));
        i_mode = 2'b11; #1;
        check("mode11_is_clock", dut_vec, pk(0, 0, 0, 60, 1, 0));
        i_mode = 2'b00; #1;
        check("sw_after_switch", dut_vec, pk(0, 0, 0, 60, 1, 0));

        // Clock: set 23:59:59, reach .99, one tick wraps to midnight.
        do_reset();
        i_mode = 2'b01;
        repeat (23) press(B_HOUR);
        repeat (59) press(B_MIN);
        repeat (59) press(B_SEC);
        wait_clk_value(compose(23, 59, 59, 99), "clk_reach_235959");
        check("clk_235959_99", dut_vec, pk(23, 59, 59, 99, 1, 0));
        wait_tick_next("clk_wrap_tick");
        @(negedge clk);
        check("clk_midnight", dut_vec, pk(0, 0, 0, 0, 1, 0));

        // Sec pulse coincident with carrying tick at 00:00:59.99.
        repeat (59) press(B_SEC);
        wait_clk_value(compose(0, 0, 59, 99), "clk_reach_0059");
        wait_tick_next("clk_coincide_tick");
        b_sec = 1'b1;
        @(negedge clk);
        b_sec = 1'b0;
        check("clk_tick_plus_sec", dut_vec, pk(0, 1, 1, 0, 1, 0));

        // Min adjust wraps 59->0 without touching hour; 5 ticks elapse.
        repeat (59) press(B_MIN);
        check("clk_min_wrap", dut_vec, pk(0, 0, 1, 5, 1, 0));

        // Reset mid-count with a coincident run pulse.
        i_mode = 2'b00;
        do_reset();
        press(B_RUN);
        repeat (237) @(negedge clk);
        rst = 1'b1; b_run = 1'b1;
        @(negedge clk);
        rst = 1'b0; b_run = 1'b0;
        check("rst_priority", dut_vec, pk(0, 0, 0, 0, 0, 0));
        repeat (20) @(negedge clk);
        check("rst_stays_stopped", dut_vec, pk(0, 0, 0, 0, 0, 0));

`ifdef COUNTDOWN_EN
        // Countdown: preset 1 s, run, 100 ticks to expiry.
        do_reset();
        i_mode = 2'b10;
        press(B_SEC);
        check("cd_preset", dut_vec, pk(0, 0, 1, 0, 0, 0));
        press(B_RUN);
        repeat (998) @(negedge clk);
        check("cd_expired", dut_vec, pk(0, 0, 0, 0, 0, 1));
        press(B_RUN);
        check("cd_run_clears_exp", dut_vec, pk(0, 0, 0, 0, 0, 0));
        press(B_MIN);
        press(B_RUN);
        repeat (15) @(negedge clk);
        press(B_HOUR);
        press(B_CLEAR);
        check("cd_clear", dut_vec, pk(0, 0, 0, 0, 0, 0));
`else
        // Without the countdown engine, mode 10 is the stopwatch.
        do_reset();
        i_mode = 2'b10;
        press(B_RUN);
        repeat (1000) @(negedge clk);
        check("mode10_as_sw", dut_vec, pk(0, 0, 1, 0, 1, 0));
        i_mode = 2'b00; #1;
        check("mode10_same_sw", dut_vec, pk(0, 0, 1, 0, 1, 0));
        i_mode = 2'b10;
        press(B_CLEAR);
        check("mode10_clear", dut_vec, pk(0, 0, 0, 0, 0, 0));
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
